// File: rtl/rotation_engine.sv
// Memory-to-memory image rotation engine: APB register slave plus an AHB master
// that moves one 32-bit pixel at a time, with a single transfer outstanding.
module rotation_engine #(
  parameter int DIM_W = 16
) (
  input  logic        I_HCLK,
  input  logic        I_HRESET,
  input  logic [31:0] I_REG_PADDR,
  input  logic [31:0] I_REG_PWDATA,
  input  logic        I_REG_PSEL,
  input  logic        I_REG_PENABLE,
  input  logic        I_REG_PWRITE,
  output logic [31:0] O_REG_PRDATA,
  output logic [31:0] O_DMA_HADDR,
  output logic [31:0] O_DMA_HWDATA,
  output logic [1:0]  O_DMA_HTRANS,
  output logic [2:0]  O_DMA_HSIZE,
  output logic [3:0]  O_DMA_HBURST,
  output logic        O_DMA_HBUSREQ,
  output logic        O_DMA_HWRITE,
  input  logic        I_DMA_HGRANT,
  input  logic        I_DMA_HREADY,
  input  logic [31:0] I_DMA_HRDATA,
  output logic        O_INTR_DONE
);

  localparam logic [7:0] A_SRC   = 8'h00;
  localparam logic [7:0] A_DST   = 8'h04;
  localparam logic [7:0] A_HGT   = 8'h08;
  localparam logic [7:0] A_WID   = 8'h0C;
  localparam logic [7:0] A_MODE  = 8'h18;
  localparam logic [7:0] A_DIR   = 8'h1C;
  localparam logic [7:0] A_START = 8'h20;
  localparam logic [7:0] A_SRST  = 8'h24;
  localparam logic [7:0] A_ICLR  = 8'h34;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_ADDR,
    S_WR_DATA,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [DIM_W-1:0] height_q;
  logic [DIM_W-1:0] width_q;
  logic [1:0]       mode_q;
  logic             dir_q;
  logic             intr_q;
  logic [DIM_W-1:0] r_q;
  logic [DIM_W-1:0] c_q;
  logic [31:0]      pix_q;

  logic [7:0] addr;
  logic       apb_wr;
  logic       cfg_wr;
  logic       start_wr;
  logic       srst_wr;
  logic       iclr_wr;
  logic       last_px;
  logic       last_col;
  logic       busy;

  logic [31:0] unused_paddr;
  assign unused_paddr = {I_REG_PADDR[31:8], 8'h00};

  assign addr     = I_REG_PADDR[7:0];
  assign busy     = (state_q != S_IDLE);
  assign apb_wr   = I_REG_PSEL & I_REG_PENABLE & I_REG_PWRITE;
  assign cfg_wr   = apb_wr & ~busy;
  assign start_wr = apb_wr & (addr == A_START) & I_REG_PWDATA[0];
  assign srst_wr  = apb_wr & (addr == A_SRST) & I_REG_PWDATA[0];
  assign iclr_wr  = apb_wr & (addr == A_ICLR) & I_REG_PWDATA[0];
  assign last_col = (c_q == width_q - ONE);
  assign last_px  = last_col & (r_q == height_q - ONE);

  logic [1:0]  rot;
  logic [31:0] r32, c32, h32, w32;
  logic [31:0] src_idx, dst_idx;
  logic [31:0] src_addr, dst_addr;

  assign rot = dir_q ? (2'd0 - mode_q) : mode_q;
  assign r32 = 32'(r_q);
  assign c32 = 32'(c_q);
  assign h32 = 32'(height_q);
  assign w32 = 32'(width_q);

  always_comb begin
    src_idx = r32 * w32 + c32;
    dst_idx = src_idx;
    unique case (rot)
      2'd0: dst_idx = src_idx;
      2'd1: dst_idx = c32 * h32 + h32 - 32'd1 - r32;
      2'd2: dst_idx = (h32 - 32'd1 - r32) * w32 + w32 - 32'd1 - c32;
      2'd3: dst_idx = (w32 - 32'd1 - c32) * h32 + r32;
      default: dst_idx = src_idx;
    endcase
    src_addr = src_q + {src_idx[29:0], 2'b00};
    dst_addr = dst_q + {dst_idx[29:0], 2'b00};
  end

  // Address phase is only presented once the arbiter has granted the bus.
  always_comb begin
    O_DMA_HTRANS  = T_IDLE;
    O_DMA_HADDR   = 32'h0;
    O_DMA_HWRITE  = 1'b0;
    O_DMA_HWDATA  = 32'h0;
    O_DMA_HBUSREQ = 1'b0;
    unique case (state_q)
      S_RD_ADDR: begin
        O_DMA_HBUSREQ = 1'b1;
        if (I_DMA_HGRANT) begin
          O_DMA_HTRANS = T_NONSEQ;
          O_DMA_HADDR  = src_addr;
        end
      end
      S_RD_DATA: O_DMA_HBUSREQ = 1'b1;
      S_WR_ADDR: begin
        O_DMA_HBUSREQ = 1'b1;
        if (I_DMA_HGRANT) begin
          O_DMA_HTRANS = T_NONSEQ;
          O_DMA_HADDR  = dst_addr;
          O_DMA_HWRITE = 1'b1;
        end
      end
      S_WR_DATA: begin
        O_DMA_HBUSREQ = 1'b1;
        O_DMA_HWDATA  = pix_q;
      end
      default: ;
    endcase
  end

  assign O_DMA_HSIZE  = 3'b010;
  assign O_DMA_HBURST = 4'b0000;
  assign O_INTR_DONE  = intr_q;

  always_comb begin
    O_REG_PRDATA = 32'h0;
    if (I_REG_PSEL && !I_REG_PWRITE) begin
      case (addr)
        A_SRC:   O_REG_PRDATA = src_q;
        A_DST:   O_REG_PRDATA = dst_q;
        A_HGT:   O_REG_PRDATA = 32'(height_q);
        A_WID:   O_REG_PRDATA = 32'(width_q);
        A_MODE:  O_REG_PRDATA = {30'h0, mode_q};
        A_DIR:   O_REG_PRDATA = {31'h0, dir_q};
        A_START: O_REG_PRDATA = {31'h0, busy};
        A_ICLR:  O_REG_PRDATA = {31'h0, intr_q};
        default: O_REG_PRDATA = 32'h0;
      endcase
    end
  end

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      state_q  <= S_IDLE;
      src_q    <= 32'h0;
      dst_q    <= 32'h0;
      height_q <= '0;
      width_q  <= '0;
      mode_q   <= 2'd0;
      dir_q    <= 1'b0;
      intr_q   <= 1'b0;
      r_q      <= '0;
      c_q      <= '0;
      pix_q    <= 32'h0;
    end else begin
      if (cfg_wr) begin
        case (addr)
          A_SRC:  src_q    <= {I_REG_PWDATA[31:2], 2'b00};
          A_DST:  dst_q    <= {I_REG_PWDATA[31:2], 2'b00};
          A_HGT:  height_q <= I_REG_PWDATA[DIM_W-1:0];
          A_WID:  width_q  <= I_REG_PWDATA[DIM_W-1:0];
          A_MODE: mode_q   <= I_REG_PWDATA[1:0];
          A_DIR:  dir_q    <= I_REG_PWDATA[0];
          default: ;
        endcase
      end
      if (iclr_wr) intr_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_wr) begin
            intr_q <= 1'b0;
            r_q    <= '0;
            c_q    <= '0;
            if (height_q == '0 || width_q == '0) state_q <= S_DONE;
            else state_q <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: begin
          if (I_DMA_HGRANT && I_DMA_HREADY) state_q <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (I_DMA_HREADY) begin
            pix_q   <= I_DMA_HRDATA;
            state_q <= S_WR_ADDR;
          end
        end
        S_WR_ADDR: begin
          if (I_DMA_HGRANT && I_DMA_HREADY) state_q <= S_WR_DATA;
        end
        S_WR_DATA: begin
          if (I_DMA_HREADY) begin
            if (last_px) begin
              state_q <= S_DONE;
            end else begin
              state_q <= S_RD_ADDR;
              if (last_col) begin
                c_q <= '0;
                r_q <= r_q + ONE;
              end else begin
                c_q <= c_q + ONE;
              end
            end
          end
        end
        S_DONE: begin
          intr_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // Soft reset overrides any in-flight transfer and a pending done event.
      if (srst_wr) begin
        state_q <= S_IDLE;
        intr_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rotation_engine.sv
// Self-checking bench for rotation_engine: directed and randomized jobs
// compared against a coordinate-rotation reference model.
module tb_rotation_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] paddr = 32'h0;
  logic [31:0] pwdata = 32'h0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] prdata;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hburst;
  logic        hbusreq;
  logic        hwrite;
  logic        hgrant = 1'b0;
  logic        hready = 1'b1;
  logic [31:0] hrdata = 32'h0;
  logic        intr;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rd[$];
  logic [31:0] exp_wr[$];
  logic [31:0] exp_dat[$];
  logic [31:0] key;

  always #5 clk = ~clk;

  rotation_engine #(.DIM_W(16)) dut (
    .I_HCLK       (clk),
    .I_HRESET     (rst),
    .I_REG_PADDR  (paddr),
    .I_REG_PWDATA (pwdata),
    .I_REG_PSEL   (psel),
    .I_REG_PENABLE(penable),
    .I_REG_PWRITE (pwrite),
    .O_REG_PRDATA (prdata),
    .O_DMA_HADDR  (haddr),
    .O_DMA_HWDATA (hwdata),
    .O_DMA_HTRANS (htrans),
    .O_DMA_HSIZE  (hsize),
    .O_DMA_HBURST (hburst),
    .O_DMA_HBUSREQ(hbusreq),
    .O_DMA_HWRITE (hwrite),
    .I_DMA_HGRANT (hgrant),
    .I_DMA_HREADY (hready),
    .I_DMA_HRDATA (hrdata),
    .O_INTR_DONE  (intr)
  );

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = {24'h0, a}; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = {24'h0, a};
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // Destination found by rotating the pixel's coordinates 90 deg cw, rot times.
  function automatic logic [31:0] dst_of(logic [31:0] dst, int r, int c,
                                         int h, int w, int rot);
    int nr, nc, nh, nw, t;
    nr = r; nc = c; nh = h; nw = w;
    for (int k = 0; k < rot; k++) begin
      t = nr; nr = nc; nc = nh - 1 - t;
      t = nh; nh = nw; nw = t;
    end
    return dst + 32'(4 * (nr * nw + nc));
  endfunction

  task automatic cfg(input int h, input int w, input int mode, input int dir,
                     input logic [31:0] src, input logic [31:0] dst);
    apb_write(8'h00, src);
    apb_write(8'h04, dst);
    apb_write(8'h08, 32'(h));
    apb_write(8'h0C, 32'(w));
    apb_write(8'h18, 32'(mode));
    apb_write(8'h1C, 32'(dir));
  endtask

  task automatic prep_model(input int h, input int w, input int mode,
                            input int dir, input logic [31:0] src,
                            input logic [31:0] dst, input logic [31:0] k);
    int eff;
    logic [31:0] s, sb, db;
    sb = {src[31:2], 2'b00};
    db = {dst[31:2], 2'b00};
    eff = dir ? (4 - mode) % 4 : mode;
    key = k;
    exp_rd.delete(); exp_wr.delete(); exp_dat.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        s = sb + 32'(4 * (r * w + c));
        exp_rd.push_back(s);
        exp_wr.push_back(dst_of(db, r, c, h, w, eff));
        exp_dat.push_back(s ^ k);
      end
  endtask

  // Acts as bus arbiter and memory; starts on a negedge with the job running.
  task automatic run_bus(input int wmode, output logic [31:0] first_wr);
    int n, rd_i, wr_i, post, wcnt, budget;
    bit prd, pwr, was_pend;
    logic [31:0] rda;
    n = exp_rd.size();
    rd_i = 0; wr_i = 0; post = 0; wcnt = 0;
    prd = 0; pwr = 0; rda = 0;
    first_wr = 32'hDEAD_BEEF;
    budget = 200 + 40 * n;
    forever begin
      case (wmode)
        0: begin hgrant = 1'b1; hready = 1'b1; end
        1: begin hgrant = 1'b1; hready = !((prd || pwr) && wcnt < 3); end
        default: begin
          hgrant = ($urandom_range(0, 3) != 0);
          hready = ($urandom_range(0, 3) != 0);
        end
      endcase
      hrdata = prd ? (rda ^ key) : $urandom;
      #1;
      if (wr_i == n) begin
        post++;
        checks++;
        if (post == 1 && intr !== 1'b0) begin
          errors++;
          $display("FAIL intr_early: got %b want 0", intr);
        end
        if (post == 2) begin
          if (intr !== 1'b1) begin
            errors++;
            $display("FAIL intr_rise: got %b want 1", intr);
          end
          break;
        end
      end else begin
        checks++;
        if (hbusreq !== 1'b1) begin
          errors++;
          $display("FAIL busreq_job: got %b want 1", hbusreq);
        end
        was_pend = prd || pwr;
        if (pwr) begin
          checks++;
          if (hwdata !== exp_dat[wr_i]) begin
            errors++;
            $display("FAIL hwdata[%0d]: got %h want %h", wr_i, hwdata,
                     exp_dat[wr_i]);
          end
          if (hready) begin pwr = 0; wr_i++; wcnt = 0; end
          else wcnt++;
        end else if (prd) begin
          if (hready) begin prd = 0; wcnt = 0; end
          else wcnt++;
        end
        if (htrans === 2'b10) begin
          checks++;
          if (was_pend || !hgrant) begin
            errors++;
            $display("FAIL nonseq_illegal: got pend=%b grant=%b want 0/1",
                     was_pend, hgrant);
          end else if (hready) begin
            checks++;
            if (hwrite !== (rd_i != wr_i)) begin
              errors++;
              $display("FAIL hwrite_order: got %b want %b", hwrite,
                       rd_i != wr_i);
            end else if (hwrite) begin
              checks++;
              if (haddr !== exp_wr[wr_i]) begin
                errors++;
                $display("FAIL wr_addr[%0d]: got %h want %h", wr_i, haddr,
                         exp_wr[wr_i]);
              end
              if (wr_i == 0) first_wr = haddr;
              pwr = 1;
            end else begin
              if (rd_i >= n) begin
                errors++;
                $display("FAIL extra_read: got %0d reads want %0d", rd_i + 1, n);
                break;
              end
              checks++;
              if (haddr !== exp_rd[rd_i]) begin
                errors++;
                $display("FAIL rd_addr[%0d]: got %h want %h", rd_i, haddr,
                         exp_rd[rd_i]);
              end
              rda = haddr;
              rd_i++;
              prd = 1;
            end
          end
        end
      end
      budget--;
      if (budget == 0) begin
        errors++;
        $display("FAIL job_timeout: got %0d writes want %0d", wr_i, n);
        break;
      end
      @(negedge clk);
    end
    hgrant = 1'b0;
    hready = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({htrans, hbusreq, intr, hwrite} !== 5'b0 || haddr !== 0 ||
        hwdata !== 0 || hsize !== 3'b010 || hburst !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got tr=%b req=%b int=%b a=%h d=%h sz=%b bu=%h want idle",
               htrans, hbusreq, intr, haddr, hwdata, hsize, hburst);
    end
    rst = 1'b0;
    for (int a = 0; a < 64; a += 4) begin
      apb_read(8'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg[%h]: got %h want 0", a, d);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] v[6];
    logic [31:0] m[6];
    logic [7:0]  ad[6];
    logic [7:0]  un[5];
    logic [31:0] d;
    ad = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h18, 8'h1C};
    m  = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_FFFF, 32'h0000_FFFF,
           32'h3, 32'h1};
    un = '{8'h10, 8'h14, 8'h28, 8'h2C, 8'h30};
    for (int i = 0; i < 6; i++) begin
      v[i] = $urandom;
      apb_write(ad[i], v[i]);
    end
    for (int i = 0; i < 5; i++) apb_write(un[i], $urandom);
    for (int i = 0; i < 6; i++) begin
      apb_read(ad[i], d);
      checks++;
      if (d !== (v[i] & m[i])) begin
        errors++;
        $display("FAIL reg_rb[%h]: got %h want %h", ad[i], d, v[i] & m[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      apb_read(un[i], d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL unmapped[%h]: got %h want 0", un[i], d);
      end
    end
    @(negedge clk);
    paddr = 32'h0; psel = 1'b0;
    #1;
    checks++;
    if (prdata !== 32'h0) begin
      errors++;
      $display("FAIL prdata_nosel: got %h want 0", prdata);
    end
  endtask

  task automatic test_zero_size();
    logic [31:0] d;
    cfg(8, 0, 0, 0, 32'h100, 32'h200);
    apb_write(8'h20, 32'h1);
    #1;
    checks++;
    if (hbusreq !== 1'b0 || intr !== 1'b0) begin
      errors++;
      $display("FAIL zero_t1: got req=%b int=%b want 0/0", hbusreq, intr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (hbusreq !== 1'b0 || intr !== 1'b1) begin
      errors++;
      $display("FAIL zero_t2: got req=%b int=%b want 0/1", hbusreq, intr);
    end
    apb_read(8'h20, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL zero_busy: got %h want 0", d);
    end
  endtask

  task automatic dir_job(input int mode, input int dir, input int wmode,
                         input logic [31:0] want_first);
    logic [31:0] fw;
    cfg(2, 3, mode, dir, 32'h1000, 32'h2000);
    prep_model(2, 3, mode, dir, 32'h1000, 32'h2000, 32'h0);
    apb_write(8'h20, 32'h1);
    run_bus(wmode, fw);
    checks++;
    if (fw !== want_first) begin
      errors++;
      $display("FAIL first_wr m%0d d%0d: got %h want %h", mode, dir, fw,
               want_first);
    end
  endtask

  task automatic test_rotate();
    dir_job(1, 0, 0, 32'h2004);
    dir_job(1, 1, 0, 32'h2010);
    dir_job(2, 0, 0, 32'h2014);
    dir_job(3, 0, 0, 32'h2010);
    dir_job(0, 1, 0, 32'h2000);
  endtask

  task automatic test_wait_states();
    dir_job(1, 0, 1, 32'h2004);
    dir_job(2, 1, 1, 32'h2014);
  endtask

  task automatic test_random();
    int h, w, md, dr;
    logic [31:0] s, t, fw;
    for (int j = 0; j < 10; j++) begin
      h = $urandom_range(1, 5);
      w = $urandom_range(1, 5);
      md = $urandom_range(0, 3);
      dr = $urandom_range(0, 1);
      s = $urandom;
      t = (j == 3) ? 32'hFFFF_FFF0 : $urandom;
      cfg(h, w, md, dr, s, t);
      prep_model(h, w, md, dr, s, t, $urandom);
      apb_write(8'h20, 32'h1);
      run_bus(j % 3, fw);
    end
  endtask

  task automatic test_soft_reset();
    logic [31:0] d, fw;
    cfg(4, 4, 1, 0, 32'h4000, 32'h8000);
    apb_write(8'h20, 32'h1);
    hgrant = 1'b1; hready = 1'b1;
    repeat (5) @(negedge clk);
    hready = 1'b0;
    apb_write(8'h24, 32'h1);
    #1;
    checks++;
    if (hbusreq !== 1'b0 || htrans !== 2'b00 || intr !== 1'b0) begin
      errors++;
      $display("FAIL srst_abort: got req=%b tr=%b int=%b want 0/00/0",
               hbusreq, htrans, intr);
    end
    hgrant = 1'b0; hready = 1'b1;
    apb_read(8'h20, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL srst_busy: got %h want 0", d);
    end
    apb_read(8'h08, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL srst_keep_h: got %h want 4", d);
    end
    apb_write(8'h0C, 32'h0);
    apb_write(8'h20, 32'h1);
    repeat (2) @(negedge clk);
    apb_read(8'h34, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL intr_status: got %h want 1", d);
    end
    apb_write(8'h34, 32'h1);
    #1;
    checks++;
    if (intr !== 1'b0) begin
      errors++;
      $display("FAIL intr_clear: got %b want 0", intr);
    end
    cfg(2, 3, 2, 0, 32'h1000, 32'h2000);
    prep_model(2, 3, 2, 0, 32'h1000, 32'h2000, 32'h0);
    apb_write(8'h20, 32'h1);
    apb_read(8'h20, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL busy_flag: got %h want 1", d);
    end
    apb_write(8'h08, 32'h7);
    apb_write(8'h20, 32'h1);
    apb_read(8'h08, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL busy_cfg_ignored: got %h want 2", d);
    end
    run_bus(0, fw);
  endtask

  task automatic test_hard_reset_midjob();
    logic [31:0] d;
    cfg(3, 3, 3, 1, 32'hA000, 32'hB000);
    apb_write(8'h20, 32'h1);
    hgrant = 1'b1; hready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (hbusreq !== 1'b0 || htrans !== 2'b00 || intr !== 1'b0) begin
      errors++;
      $display("FAIL hrst_abort: got req=%b tr=%b int=%b want 0/00/0",
               hbusreq, htrans, intr);
    end
    rst = 1'b0; hgrant = 1'b0;
    apb_read(8'h08, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL hrst_regs: got %h want 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_zero_size();
    test_rotate();
    test_wait_states();
    test_random();
    test_soft_reset();
    test_hard_reset_midjob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotation_engine.md
Name: rotation_engine

Overview:
- Memory-to-memory image rotation engine: APB-style slave register port for configuration, AHB master (DMA) port for pixel moves.
- Reads each 32-bit pixel of an H x W source image, writes it to the rotated position in the destination buffer, then raises a level interrupt.
- Sits between the CPU peripheral bus and the system AHB as a bus-mastering accelerator.

Parameters:
- DIM_W, 16, width of the height/width fields; max image side is 2^DIM_W-1.

Ports:
- I_HCLK in 1: single clock for the APB and AHB sides.
- I_HRESET in 1: reset, synchronous, active-high.
- I_REG_PADDR in 32: register address; bits [7:0] decoded.
- I_REG_PWDATA in 32: register write data.
- I_REG_PSEL in 1: slave select.
- I_REG_PENABLE in 1: access phase.
- I_REG_PWRITE in 1: 1=write, 0=read.
- O_REG_PRDATA out 32: read data.
- O_DMA_HADDR out 32: AHB address.
- O_DMA_HWDATA out 32: AHB write data.
- O_DMA_HTRANS out 2: IDLE=00, NONSEQ=10.
- O_DMA_HSIZE out 3: constant 010 (word).
- O_DMA_HBURST out 4: constant 0 (SINGLE).
- O_DMA_HBUSREQ out 1: bus request.
- O_DMA_HWRITE out 1: transfer direction.
- I_DMA_HGRANT in 1: bus grant.
- I_DMA_HREADY in 1: transfer ready.
- I_DMA_HRDATA in 32: AHB read data.
- O_INTR_DONE out 1: job-done interrupt, level.

Behaviour:
- Register map (byte offsets):
  - 0x00 SRC[31:0], bits[1:0] read 0.
  - 0x04 DST[31:0], bits[1:0] read 0.
  - 0x08 HEIGHT[DIM_W-1:0].
  - 0x0C WIDTH[DIM_W-1:0].
  - 0x18 MODE[1:0]: 0=0°, 1=90°, 2=180°, 3=270°.
  - 0x1C DIRECTION[0]: 0=clockwise, 1=counter-clockwise.
  - 0x20 START: write bit0=1 starts a job; read bit0=busy.
  - 0x24 RESET: write bit0=1 is a soft reset; reads 0.
  - 0x34 INTR_CLEAR: write bit0=1 clears the interrupt; read bit0=interrupt status.
  - All other offsets read 0; writes to them are ignored.
- APB timing:
  - A write commits at the clock edge where PSEL&PENABLE&PWRITE=1. No wait states.
  - PRDATA is combinational from PADDR while PSEL=1 and PWRITE=0; otherwise 0.
- Config registers ignore writes while busy. They keep their values across soft reset.
- Reset (I_HRESET):
  - All registers 0; FSM IDLE; HTRANS=00, HADDR=0, HWDATA=0, HWRITE=0, HBUSREQ=0, INTR=0.
  - HSIZE=010 and HBURST=0 at all times.
- Effective clockwise rotation: R = DIRECTION ? (4-MODE) mod 4 : MODE.
- Pixel order: source pixel (r,c) is scanned row-major, r over 0..H-1, c over 0..W-1. Source address = SRC + 4*(r*W+c).
- Destination address (all arithmetic is 32-bit, wraps mod 2^32):
  - R=0: DST + 4*(r*W + c).
  - R=1: DST + 4*(c*H + H-1-r).
  - R=2: DST + 4*((H-1-r)*W + W-1-c).
  - R=3: DST + 4*((W-1-c)*H + r).
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE.
  - IDLE + START write: if H=0 or W=0, go to DONE (no bus activity). Otherwise latch counters r=c=0, clear INTR, go to RD_ADDR.
  - HBUSREQ=1 in every state from RD_ADDR through WR_DATA.
  - RD_ADDR / WR_ADDR: when HGRANT=1, drive HTRANS=NONSEQ, HADDR, and HWRITE (0 for read, 1 for write). Advance to the data state on the edge where HGRANT&HREADY=1.
  - Data states drive HTRANS=IDLE.
  - RD_DATA: on HREADY=1, capture HRDATA into the pixel register and go to WR_ADDR.
  - WR_DATA: HWDATA = pixel register throughout. On HREADY=1: if last pixel, go to DONE; else increment c (wrap to 0 and increment r) and go to RD_ADDR.
  - Only one transfer is outstanding at a time.
  - DONE: set INTR, go to IDLE after one cycle.
- Interrupt:
  - INTR rises one cycle after the final WR_DATA completes.
  - INTR holds until an INTR_CLEAR write, a soft reset, or a new START.
  - If a clear and a set land on the same edge, set wins.
- START while busy is ignored.
- Soft reset at any point: next cycle FSM=IDLE, HBUSREQ=0, HTRANS=IDLE, INTR=0. A transfer in flight is abandoned.
- A hard reset mid-job behaves the same as a soft reset, and also clears the registers.

Test Plan:
- Reset, then read all registers → every read returns 0. Check HTRANS=00, HBUSREQ=0, INTR=0.
- HEIGHT=8, WIDTH=0, START → no HBUSREQ; INTR=1 two cycles after the START write; START read returns 0.
- SRC=0x1000, DST=0x2000, H=2, W=3, MODE=1, DIR=0; HGRANT=HREADY=1, HRDATA=address echo → write addresses in order 0x2004, 0x200C, 0x2014, 0x2000, 0x2008, 0x2010. HWDATA equals the matching source address; INTR then rises.
- Same image with MODE=1, DIR=1 → writes hit 0x2010, 0x2008, 0x2000, 0x2014, 0x200C, 0x2004. MODE=2 → first write at 0x2014.
- HREADY low for 3 cycles during RD_DATA and WR_DATA → state and HWDATA are held; no second NONSEQ is issued; the result is identical to the no-wait case.
- Soft reset written mid-job, then INTR_CLEAR write, then START write while busy → the job aborts (IDLE, HBUSREQ=0); the clear drops INTR; the START while busy is ignored.
